// File: rtl/adder_cosim_pkg.sv
// Shared definitions for the cosim adder: operand/result widths,
// checker FSM states and the operand LFSR feedback taps.
package adder_cosim_pkg;

    localparam int ADD_A_W = 17;
    localparam int ADD_B_W = 5;
    localparam int ADD_C_W = 10;
    localparam int LFSR_W  = ADD_A_W + ADD_B_W;

    // x^22 + x^21 + 1
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 22'h300000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_e;

endpackage

// File: rtl/operand_lfsr.sv
// Fibonacci LFSR operand source with synchronous load and single-step.
// A zero seed would lock up the register, so it is replaced by 1.
module operand_lfsr #(
    parameter int            W    = 22,
    parameter logic [W-1:0]  SEED = W'(1),
    parameter logic [W-1:0]  TAPS = W'(3) << (W - 2)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         step_i,
    output logic [W-1:0] state_o
);

    localparam logic [W-1:0] INIT = (SEED == '0) ? W'(1) : SEED;

    logic [W-1:0] state_q;
    logic [W-1:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = INIT;
        end else if (step_i) begin
            state_d = {state_q[W-2:0], ^(state_q & TAPS)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/adder_stim_checker.sv
// Stimulus initiator and result checker for the cosim adder responder.
// Runs num_vectors handshaked operand pairs and collects statistics.
module adder_stim_checker
    import adder_cosim_pkg::*;
#(
    parameter int A_WIDTH   = ADD_A_W,
    parameter int B_WIDTH   = ADD_B_W,
    parameter int C_WIDTH   = ADD_C_W,
    parameter int CNT_WIDTH = 16,
    parameter logic [A_WIDTH+B_WIDTH-1:0] SEED = 22'h1ACE1,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 mode,
    input  logic [CNT_WIDTH-1:0] num_vectors,
    output logic [A_WIDTH-1:0]   a_out,
    output logic [B_WIDTH-1:0]   b_out,
    output logic                 op_valid,
    input  logic                 op_ready,
    input  logic [C_WIDTH-1:0]   res_in,
    input  logic                 res_valid,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] pass_count,
    output logic [CNT_WIDTH-1:0] fail_count,
    output logic [CNT_WIDTH-1:0] timeout_count,
    output logic [CNT_WIDTH-1:0] first_fail_idx,
    output logic [C_WIDTH-1:0]   first_fail_got
);

    localparam int LW = A_WIDTH + B_WIDTH;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    state_e               state_q;
    logic                 mode_q;
    logic [CNT_WIDTH-1:0] num_q;
    logic [CNT_WIDTH-1:0] idx_q;
    logic [TW-1:0]        tcnt_q;
    logic [C_WIDTH-1:0]   exp_q;
    logic [C_WIDTH-1:0]   got_q;
    logic                 ff_q;
    logic [A_WIDTH-1:0]   a_q;
    logic [B_WIDTH-1:0]   b_q;
    logic                 vld_q;
    logic                 done_q;
    logic [CNT_WIDTH-1:0] pass_q;
    logic [CNT_WIDTH-1:0] fail_q;
    logic [CNT_WIDTH-1:0] tout_q;
    logic [CNT_WIDTH-1:0] ffidx_q;
    logic [C_WIDTH-1:0]   ffgot_q;

    logic [LW-1:0]        lfsr;
    logic [A_WIDTH-1:0]   gen_a;
    logic [B_WIDTH-1:0]   gen_b;
    logic [CNT_WIDTH-1:0] idx_nx;
    logic                 start_ok;
    logic                 to_hit;
    logic                 adv;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(
        input logic [CNT_WIDTH-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

    assign start_ok = start && (state_q == S_IDLE || state_q == S_DONE);
    assign to_hit   = (state_q == S_WAIT) && !res_valid && (tcnt_q == T_LAST);
    assign adv      = (state_q == S_CHECK) || to_hit;
    assign idx_nx   = idx_q + 1'b1;

    assign gen_a = mode_q ? A_WIDTH'(idx_q) : lfsr[LW-1:B_WIDTH];
    assign gen_b = mode_q ? idx_q[B_WIDTH-1:0] : lfsr[B_WIDTH-1:0];

    operand_lfsr #(
        .W    (LW),
        .SEED (SEED),
        .TAPS (LFSR_TAPS)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load_i  (start_ok),
        .step_i  (adv),
        .state_o (lfsr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            num_q   <= '0;
            idx_q   <= '0;
            tcnt_q  <= '0;
            exp_q   <= '0;
            got_q   <= '0;
            ff_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= '0;
            fail_q  <= '0;
            tout_q  <= '0;
            ffidx_q <= '0;
            ffgot_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        num_q   <= num_vectors;
                        mode_q  <= mode;
                        idx_q   <= '0;
                        ff_q    <= 1'b0;
                        pass_q  <= '0;
                        fail_q  <= '0;
                        tout_q  <= '0;
                        ffidx_q <= '0;
                        ffgot_q <= '0;
                        done_q  <= (num_vectors == '0);
                        state_q <= (num_vectors == '0) ? S_DONE : S_LOAD;
                    end
                end
                S_LOAD: begin
                    a_q     <= gen_a;
                    b_q     <= gen_b;
                    exp_q   <= C_WIDTH'(gen_a + A_WIDTH'(gen_b));
                    vld_q   <= 1'b1;
                    state_q <= S_SEND;
                end
                S_SEND: begin
                    if (op_ready) begin
                        vld_q   <= 1'b0;
                        tcnt_q  <= '0;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (res_valid) begin
                        got_q   <= res_in;
                        state_q <= S_CHECK;
                    end else if (to_hit) begin
                        tout_q <= sat_inc(tout_q);
                        fail_q <= sat_inc(fail_q);
                        if (!ff_q) begin
                            ff_q    <= 1'b1;
                            ffidx_q <= idx_q;
                            ffgot_q <= '0;
                        end
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
                S_CHECK: begin
                    if (got_q == exp_q) begin
                        pass_q <= sat_inc(pass_q);
                    end else begin
                        fail_q <= sat_inc(fail_q);
                        if (!ff_q) begin
                            ff_q    <= 1'b1;
                            ffidx_q <= idx_q;
                            ffgot_q <= got_q;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
            // advance step shared by CHECK and WAIT timeout
            if (adv) begin
                idx_q <= idx_nx;
                if (idx_nx == num_q) begin
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                end else begin
                    state_q <= S_LOAD;
                end
            end
        end
    end

    assign a_out          = a_q;
    assign b_out          = b_q;
    assign op_valid       = vld_q;
    assign done           = done_q;
    assign pass_count     = pass_q;
    assign fail_count     = fail_q;
    assign timeout_count  = tout_q;
    assign first_fail_idx = ffidx_q;
    assign first_fail_got = ffgot_q;
    assign busy = (state_q == S_LOAD) || (state_q == S_SEND) ||
                  (state_q == S_WAIT) || (state_q == S_CHECK);

endmodule

// File: tb/tb_adder_stim_checker.sv
// Directed bench for adder_stim_checker with a behavioural responder
// that can corrupt bit 3, stay silent, or stall op_ready.
module tb_adder_stim_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [15:0] num_vectors = '0;
    logic [16:0] a_out;
    logic [4:0]  b_out;
    logic        op_valid;
    logic        op_ready;
    logic [9:0]  res_in;
    logic        res_valid;
    logic        busy;
    logic        done;
    logic [15:0] pass_count;
    logic [15:0] fail_count;
    logic [15:0] timeout_count;
    logic [15:0] first_fail_idx;
    logic [9:0]  first_fail_got;

    int total = 0;
    int bad = 0;

    // responder controls: 0 ideal, 1 clear c[3], 2 silent
    int   rmode = 0;
    logic rdy_en = 1'b1;
    logic rv_resp = 1'b0;
    logic rv_stray = 1'b0;
    logic [9:0] c_resp = '0;
    logic pend = 1'b0;
    logic [9:0] pend_c = '0;
    int nacc = 0;
    int acc_a [0:2047];
    int acc_b [0:2047];
    int acc_c [0:2047];

    assign op_ready  = rdy_en;
    assign res_valid = rv_resp | rv_stray;
    assign res_in    = rv_stray ? 10'h3FF : c_resp;

    adder_stim_checker dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .mode           (mode),
        .num_vectors    (num_vectors),
        .a_out          (a_out),
        .b_out          (b_out),
        .op_valid       (op_valid),
        .op_ready       (op_ready),
        .res_in         (res_in),
        .res_valid      (res_valid),
        .busy           (busy),
        .done           (done),
        .pass_count     (pass_count),
        .fail_count     (fail_count),
        .timeout_count  (timeout_count),
        .first_fail_idx (first_fail_idx),
        .first_fail_got (first_fail_got)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        logic [9:0] c;
        rv_resp = 1'b0;
        if (!busy) nacc = 0;
        if (pend) begin
            rv_resp = 1'b1;
            c_resp  = pend_c;
            pend    = 1'b0;
        end
        if (op_valid && op_ready && !rst) begin
            c = 10'(a_out + 17'(b_out));
            if (nacc < 2048) begin
                acc_a[nacc] = int'(a_out);
                acc_b[nacc] = int'(b_out);
                acc_c[nacc] = int'(c);
                nacc++;
            end
            if (rmode == 1) c[3] = 1'b0;
            if (rmode != 2) begin
                pend   = 1'b1;
                pend_c = c;
            end
        end
    end

    task automatic check(input string tag, input longint got,
                         input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic start_run(input int nv, input logic md);
        @(negedge clk);
        num_vectors = 16'(nv);
        mode = md;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int cyc);
        cyc = 0;
        while (!done && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
        check("done_seen", done, 1);
    endtask

    initial begin
        int cyc;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", op_valid, 0);
        check("rst_pass", pass_count, 0);
        check("rst_fail", fail_count, 0);

        // zero-length run
        start_run(0, 1'b1);
        cyc = 1;
        check("nv0_done", done, 1);
        check("nv0_busy", busy, 0);
        check("nv0_pass", pass_count, 0);

        // ideal responder, index operands
        start_run(4, 1'b1);
        wait_done(100, cyc);
        check("t1_cycles", cyc, 16);
        check("t1_pass", pass_count, 4);
        check("t1_fail", fail_count, 0);
        check("t1_a0", acc_a[0], 0);
        check("t1_a3", acc_a[3], 3);
        check("t1_b3", acc_b[3], 3);

        // long run including result wrap
        start_run(1024, 1'b1);
        wait_done(5000, cyc);
        check("t2_cycles", cyc, 4096);
        check("t2_pass", pass_count, 1024);
        check("t2_fail", fail_count, 0);
        check("t2_a1000", acc_a[1000], 1000);
        check("t2_b1000", acc_b[1000], 8);
        check("t2_c1000", acc_c[1000], 1008);
        check("t2_b1023", acc_b[1023], 31);
        check("t2_c1023", acc_c[1023], 30);

        // corrupted bit 3
        rmode = 1;
        start_run(16, 1'b1);
        wait_done(200, cyc);
        check("t3_pass", pass_count, 8);
        check("t3_fail", fail_count, 8);
        check("t3_tout", timeout_count, 0);
        check("t3_ffidx", first_fail_idx, 4);
        check("t3_ffgot", first_fail_got, 0);

        // silent responder; a start while busy must be ignored
        rmode = 2;
        start_run(2, 1'b0);
        repeat (20) @(negedge clk);
        num_vectors = 16'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(2000, cyc);
        check("t4_tout", timeout_count, 2);
        check("t4_fail", fail_count, 2);
        check("t4_pass", pass_count, 0);
        check("t4_ffidx", first_fail_idx, 0);
        check("t4_ffgot", first_fail_got, 0);

        // stalled op_ready with stray result pulses, LFSR operands
        rmode = 0;
        rdy_en = 1'b0;
        start_run(2, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            rv_stray = (i % 2 == 0);
            check("t5_valid", op_valid, 1);
            check("t5_a", a_out, 3431);
            check("t5_b", b_out, 1);
            @(negedge clk);
        end
        rv_stray = 1'b0;
        check("t5_pass_hold", pass_count, 0);
        check("t5_fail_hold", fail_count, 0);
        rdy_en = 1'b1;
        wait_done(100, cyc);
        check("t5_pass", pass_count, 2);
        check("t5_fail", fail_count, 0);
        check("t5_a1", acc_a[1], 6862);
        check("t5_b1", acc_b[1], 2);

        // reset in the middle of WAIT, then a fresh run
        rmode = 2;
        start_run(5, 1'b1);
        repeat (10) @(negedge clk);
        check("t6_busy_pre", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        check("t6_valid", op_valid, 0);
        check("t6_a", a_out, 0);
        check("t6_b", b_out, 0);
        check("t6_tout", timeout_count, 0);
        check("t6_ffidx", first_fail_idx, 0);
        rmode = 0;
        start_run(3, 1'b1);
        wait_done(100, cyc);
        check("t6_cycles", cyc, 12);
        check("t6_pass", pass_count, 3);
        check("t6_fail", fail_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
